// File: rtl/bnn_load_conv_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : bnn_load_conv_sequencer
// Description : BNN input-stage controller. Clears and fills the pixel/weight
//               register bank, waits for load completion (with timeout), then
//               streams every 3x3 window position for every binary filter to
//               the XNOR-popcount datapath over a valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module bnn_load_conv_sequencer #(
  parameter int IMG_DIM      = 28,
  parameter int K            = 3,
  parameter int N_FILT       = 8,
  parameter int LOAD_TIMEOUT = 1023,
  localparam int OUT_DIM     = IMG_DIM - K + 1,
  localparam int CW          = (OUT_DIM > 1) ? $clog2(OUT_DIM) : 1,
  localparam int FW          = (N_FILT > 1) ? $clog2(N_FILT) : 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  input  logic          abort,
  input  logic          load_done,
  input  logic          out_ready,
  output logic          regs_clr_n,
  output logic          en_wr,
  output logic          win_valid,
  output logic [CW-1:0] win_row,
  output logic [CW-1:0] win_col,
  output logic [FW-1:0] filt_idx,
  output logic          win_last,
  output logic          busy,
  output logic          done,
  output logic          err
);

  localparam int TW = $clog2(LOAD_TIMEOUT + 1);

  localparam logic [CW-1:0] c_COORD_MAX   = CW'(OUT_DIM - 1);
  localparam logic [FW-1:0] c_FILT_MAX    = FW'(N_FILT - 1);
  // Counter value during the LOAD_TIMEOUT-th LOAD cycle (counter starts at 0)
  localparam logic [TW-1:0] c_TMO_LAST    = TW'(LOAD_TIMEOUT - 1);
  // Degenerate geometry where the very first beat is also the last one
  localparam logic          c_SINGLE_BEAT = (OUT_DIM == 1) && (N_FILT == 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_LOAD  = 3'd2,
    S_CONV  = 3'd3,
    S_DONE  = 3'd4,
    S_ERR   = 3'd5
  } state_t;

  state_t        r_state;
  logic [TW-1:0] r_tmo_cnt;

  logic          w_filt_wrap;
  logic          w_col_wrap;
  logic [FW-1:0] w_nxt_filt;
  logic [CW-1:0] w_nxt_col;
  logic [CW-1:0] w_nxt_row;
  logic          w_nxt_last;

  // Next window position: filter innermost, then column, then row
  always_comb begin
    w_filt_wrap = (filt_idx == c_FILT_MAX);
    w_col_wrap  = (win_col == c_COORD_MAX);
    w_nxt_filt  = w_filt_wrap ? '0 : filt_idx + 1'b1;
    w_nxt_col   = win_col;
    w_nxt_row   = win_row;
    if (w_filt_wrap) begin
      w_nxt_col = w_col_wrap ? '0 : win_col + 1'b1;
      if (w_col_wrap) begin
        w_nxt_row = win_row + 1'b1;
      end
    end
    w_nxt_last = (w_nxt_row == c_COORD_MAX) && (w_nxt_col == c_COORD_MAX) &&
                 (w_nxt_filt == c_FILT_MAX);
  end

  // Sequencer FSM with all outputs registered; abort acts like a reset
  always_ff @(posedge clk) begin
    if (!reset_n || abort) begin
      r_state    <= S_IDLE;
      r_tmo_cnt  <= '0;
      regs_clr_n <= 1'b1;
      en_wr      <= 1'b0;
      win_valid  <= 1'b0;
      win_row    <= '0;
      win_col    <= '0;
      filt_idx   <= '0;
      win_last   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      regs_clr_n <= 1'b1;
      done       <= 1'b0;
      unique case (r_state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            r_state    <= S_CLEAR;
            regs_clr_n <= 1'b0;
            busy       <= 1'b1;
            en_wr      <= 1'b0;
            err        <= 1'b0;
            r_tmo_cnt  <= '0;
            win_row    <= '0;
            win_col    <= '0;
            filt_idx   <= '0;
            win_last   <= 1'b0;
          end else if (r_state == S_DONE) begin
            r_state <= S_IDLE;
          end
        end
        S_CLEAR: begin
          r_state   <= S_LOAD;
          en_wr     <= 1'b1;
          r_tmo_cnt <= '0;
        end
        S_LOAD: begin
          // load_done takes precedence over a coincident timeout
          if (load_done) begin
            r_state   <= S_CONV;
            en_wr     <= 1'b0;
            win_valid <= 1'b1;
            win_row   <= '0;
            win_col   <= '0;
            filt_idx  <= '0;
            win_last  <= c_SINGLE_BEAT;
          end else if (r_tmo_cnt == c_TMO_LAST) begin
            r_state <= S_ERR;
            en_wr   <= 1'b0;
            busy    <= 1'b0;
            err     <= 1'b1;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
          end
        end
        S_CONV: begin
          if (out_ready) begin
            if (win_last) begin
              r_state   <= S_DONE;
              win_valid <= 1'b0;
              win_last  <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
            end else begin
              win_row  <= w_nxt_row;
              win_col  <= w_nxt_col;
              filt_idx <= w_nxt_filt;
              win_last <= w_nxt_last;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
